pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Generic two-entry skid-buffered pipeline stage with a valid/ready handshake on both sides, a flush input that injects a bubble, and zeroed control fields whenever the stage is empty.
- Breaks the combinational ready path between adjacent stages. One instance sits between each pair of pipeline stages.

Parameters:
- CTRL_W, 16: width of the control bundle (regWrite, memWrite, branch, ALUop, ...); forced to 0 when invalid or flushed.
- DATA_W, 128: width of the data bundle (PC, operands, immediate, register indices).
- CLEAR_DATA_ON_FLUSH, 1: 1 = data registers also zeroed on flush; 0 = data registers hold their value on flush, and only valid and ctrl clear.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- flush  input  1  discard all held entries this cycle (branch mispredict / hazard nop)
- in_valid  input  1  upstream presents an entry
- in_ready  output  1  stage can accept; registered, equals !skid_valid
- in_ctrl  input  CTRL_W  upstream control bundle
- in_data  input  DATA_W  upstream data bundle
- out_valid  output  1  main entry valid
- out_ready  input  1  downstream accepts
- out_ctrl  output  CTRL_W  main_ctrl when out_valid, else 0
- out_data  output  DATA_W  main_data (value unspecified when !out_valid)
- occupancy  output  2  0, 1 or 2 entries held

Behaviour:
- Reset (reset_n low, asynchronous):
  - main_valid=0, skid_valid=0; all ctrl and data registers = 0.
  - in_ready=1, out_valid=0, out_ctrl=0, occupancy=0.
- Definitions: accept = in_valid & in_ready; drain = out_valid & out_ready. All updates occur on the rising clock edge.
- State EMPTY (occ 0):
  - accept -> ONE, main <= in.
  - otherwise stay.
- State ONE (occ 1):
  - accept & drain -> ONE, main <= in.
  - accept & !drain -> TWO, skid <= in.
  - !accept & drain -> EMPTY.
  - otherwise hold.
- State TWO (occ 2):
  - in_ready=0, so no accept.
  - drain -> ONE, main <= skid, skid_valid <= 0.
  - otherwise hold.
- Ordering is strictly FIFO. Entries are never duplicated or dropped except by flush.
- Latency: 1 cycle from accept to out_valid when the stage is empty. Throughput is 1 entry per cycle while out_ready=1.
- in_ready depends only on registered state; there is no combinational path from out_ready to in_ready.
- out_ctrl is masked combinationally with out_valid, so downstream always sees an all-zero (nop) control bundle when the stage is empty.
- flush has the highest priority:
  - Next state is EMPTY regardless of accept or drain.
  - An entry offered in the same cycle is discarded even if in_ready=1.
  - A drain in the flush cycle counts as delivered; the downstream handshake completed that cycle.
  - ctrl registers are cleared; data registers are cleared only if CLEAR_DATA_ON_FLUSH=1.
- reset_n asserted mid-operation: immediate return to the reset values; all held entries are lost.
- out_ready asserted while out_valid=0: no effect.
- in_ctrl and in_data may change freely while in_valid=0.

Optional Feature:
- Macro PIPE_STAGE_PERF_EN.
- When defined, adds outputs stall_cnt[31:0] and flush_cnt[31:0]:
  - stall_cnt increments each cycle with out_valid & !out_ready.
  - flush_cnt increments each cycle with flush & (occupancy!=0).
  - Both saturate at 32'hFFFFFFFF, are reset to 0 by reset_n, and are not cleared by flush.
- When undefined, these ports and counters are absent, and the stage behaviour is otherwise identical.

Test Plan:
- Reset: reset_n=0 with in_valid=1 and ctrl=16'hFFFF -> out_valid=0, out_ctrl=0, in_ready=1, occupancy=0. Release reset; on the first accept of ctrl=16'h00A5, data=1 -> next cycle out_valid=1, out_ctrl=16'h00A5.
- Streaming: out_ready=1, push data 1..8 back-to-back -> outputs 1..8 on consecutive cycles, each 1 cycle after accept; in_ready stays 1 and occupancy stays 1.
- Backpressure/skid: push A, B, C with out_ready=0 -> A in main, B in skid, occupancy=2, in_ready=0, C held upstream. Raise out_ready -> outputs A, B, C in order with no loss.
- Flush:
  - Flush with occupancy=2 and in_valid=1 -> next cycle occupancy=0, out_ctrl=0, offered entry dropped.
  - CLEAR_DATA_ON_FLUSH=1 -> out_data=0.
  - CLEAR_DATA_ON_FLUSH=0 -> data unchanged.
- Async reset mid-run: drop reset_n between clock edges at occupancy=2 -> outputs reach the reset values immediately, without waiting for a clock edge.
- PIPE_STAGE_PERF_EN: 5 stalled cycles, then 2 flushes of a non-empty stage and 1 flush of an empty stage -> stall_cnt=5, flush_cnt=2. Preload stall_cnt near max -> holds at 32'hFFFFFFFF.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: two-entry skid-buffered pipeline register with a valid/ready
// handshake on both sides, flush-to-bubble, and a ctrl bundle that reads as zero
// whenever the stage is empty.
//
// Ports:
//   clock, reset_n          rising-edge clock, asynchronous active-low reset
//   flush                   discard every held entry and any entry offered this cycle
//   in_valid/in_ready       upstream handshake; in_ready comes straight from a flop
//   in_ctrl/in_data         upstream control and data bundles
//   out_valid/out_ready     downstream handshake
//   out_ctrl/out_data       main entry; out_ctrl is forced to zero when !out_valid
//   occupancy               number of entries held (0, 1 or 2)
//   stall_cnt, flush_cnt    saturating performance counters, present only when
//                           PIPE_STAGE_PERF_EN is defined
module pipe_stage_skid #(
  parameter int unsigned CTRL_W              = 16,
  parameter int unsigned DATA_W              = 128,
  parameter bit          CLEAR_DATA_ON_FLUSH = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  localparam int unsigned CNT_W = 32;

  logic              main_valid, main_valid_nxt;
  logic              skid_valid, skid_valid_nxt;
  logic [CTRL_W-1:0] main_ctrl,  main_ctrl_nxt;
  logic [CTRL_W-1:0] skid_ctrl,  skid_ctrl_nxt;
  logic [DATA_W-1:0] main_data,  main_data_nxt;
  logic [DATA_W-1:0] skid_data,  skid_data_nxt;
  logic              in_ready_q;
  logic              accept;
  logic              drain;

  assign accept = in_valid & in_ready_q;
  assign drain  = main_valid & out_ready;

  // Next-state for both entries; the skid slot is only ever filled while main is full.
  always_comb begin
    main_valid_nxt = main_valid;
    skid_valid_nxt = skid_valid;
    main_ctrl_nxt  = main_ctrl;
    skid_ctrl_nxt  = skid_ctrl;
    main_data_nxt  = main_data;
    skid_data_nxt  = skid_data;

    if (flush) begin
      main_valid_nxt = 1'b0;
      skid_valid_nxt = 1'b0;
      main_ctrl_nxt  = '0;
      skid_ctrl_nxt  = '0;
      if (CLEAR_DATA_ON_FLUSH) begin
        main_data_nxt = '0;
        skid_data_nxt = '0;
      end
    end else if (!main_valid) begin
      if (accept) begin
        main_valid_nxt = 1'b1;
        main_ctrl_nxt  = in_ctrl;
        main_data_nxt  = in_data;
      end
    end else if (!skid_valid) begin
      if (accept && drain) begin
        main_ctrl_nxt = in_ctrl;
        main_data_nxt = in_data;
      end else if (accept) begin
        skid_valid_nxt = 1'b1;
        skid_ctrl_nxt  = in_ctrl;
        skid_data_nxt  = in_data;
      end else if (drain) begin
        main_valid_nxt = 1'b0;
        main_ctrl_nxt  = '0;
      end
    end else begin
      // Full: in_ready is low, so only a drain can move things.
      if (drain) begin
        main_ctrl_nxt  = skid_ctrl;
        main_data_nxt  = skid_data;
        skid_valid_nxt = 1'b0;
        skid_ctrl_nxt  = '0;
      end
    end
  end

  // State registers; in_ready is precomputed so it never sees out_ready combinationally.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_ctrl  <= '0;
      skid_ctrl  <= '0;
      main_data  <= '0;
      skid_data  <= '0;
      in_ready_q <= 1'b1;
    end else begin
      main_valid <= main_valid_nxt;
      skid_valid <= skid_valid_nxt;
      main_ctrl  <= main_ctrl_nxt;
      skid_ctrl  <= skid_ctrl_nxt;
      main_data  <= main_data_nxt;
      skid_data  <= skid_data_nxt;
      in_ready_q <= ~skid_valid_nxt;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid;
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign out_data  = main_data;
  // skid_valid implies main_valid, so the pair encodes occupancy directly.
  assign occupancy = {skid_valid, main_valid & ~skid_valid};

`ifdef PIPE_STAGE_PERF_EN
  // Saturating stall and flush counters; unaffected by flush.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (main_valid && !out_ready && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush && main_valid && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: vector table plus hand-written sequences for
// reset, flush data handling and mid-cycle asynchronous reset.
module tb_pipe_stage_skid;

  localparam int unsigned CW = 16;
  localparam int unsigned DW = 128;

  logic          clock;
  logic          reset_n;
  logic          flush;
  logic          in_valid;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_ready;

  logic          in_ready,  h_in_ready;
  logic          out_valid, h_out_valid;
  logic [CW-1:0] out_ctrl,  h_out_ctrl;
  logic [DW-1:0] out_data,  h_out_data;
  logic [1:0]    occupancy, h_occupancy;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]   stall_cnt, flush_cnt, h_stall_cnt, h_flush_cnt;
`endif

  int n_cmp;
  int n_bad;

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA_ON_FLUSH(1'b1)) u_dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA_ON_FLUSH(1'b0)) u_dut_hold (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(h_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(h_out_valid), .out_ready(out_ready), .out_ctrl(h_out_ctrl), .out_data(h_out_data),
    .occupancy(h_occupancy)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(h_stall_cnt), .flush_cnt(h_flush_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [CW-1:0] ctrl_of(input logic [15:0] d);
    return d ^ 16'h5A00;
  endfunction

  function automatic logic [DW-1:0] data_of(input logic [15:0] d);
    return {d, 112'(d)};
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs, advance one edge, leave time at posedge+1 for sampling.
  task automatic step(input logic fl, input logic iv, input logic [15:0] d, input logic ordy);
    flush     = fl;
    in_valid  = iv;
    in_ctrl   = ctrl_of(d);
    in_data   = data_of(d);
    out_ready = ordy;
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic        fl;
    logic        iv;
    logic [15:0] d;
    logic        ordy;
    logic        e_ov;
    logic [15:0] e_d;
    logic        e_ir;
    logic [1:0]  e_occ;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mk(input logic fl, input logic iv, input logic [15:0] d,
                              input logic ordy, input logic e_ov, input logic [15:0] e_d,
                              input logic e_ir, input logic [1:0] e_occ);
    vec_t v;
    v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.e_ov = e_ov; v.e_d = e_d; v.e_ir = e_ir; v.e_occ = e_occ;
    return v;
  endfunction

  initial begin
    n_cmp = 0;
    n_bad = 0;

    // Streaming 1..8 with out_ready high, then drain to empty.
    for (int k = 0; k < 8; k++) begin
      vecs[k] = mk(1'b0, 1'b1, 16'(k + 1), 1'b1, 1'b1, 16'(k + 1), 1'b1, 2'd1);
    end
    vecs[8]  = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 2'd0);
    // Backpressure: A=10, B=11, C=12.
    vecs[9]  = mk(1'b0, 1'b1, 16'h0010, 1'b0, 1'b1, 16'h0010, 1'b1, 2'd1);
    vecs[10] = mk(1'b0, 1'b1, 16'h0011, 1'b0, 1'b1, 16'h0010, 1'b0, 2'd2);
    vecs[11] = mk(1'b0, 1'b1, 16'h0012, 1'b0, 1'b1, 16'h0010, 1'b0, 2'd2);
    vecs[12] = mk(1'b0, 1'b1, 16'h0012, 1'b1, 1'b1, 16'h0011, 1'b1, 2'd1);
    vecs[13] = mk(1'b0, 1'b1, 16'h0012, 1'b0, 1'b1, 16'h0011, 1'b0, 2'd2);
    vecs[14] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0012, 1'b1, 2'd1);
    vecs[15] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 2'd0);
    // Flush while full with an entry offered; the offered 22 must not appear.
    vecs[16] = mk(1'b0, 1'b1, 16'h0020, 1'b0, 1'b1, 16'h0020, 1'b1, 2'd1);
    vecs[17] = mk(1'b0, 1'b1, 16'h0021, 1'b0, 1'b1, 16'h0020, 1'b0, 2'd2);
    vecs[18] = mk(1'b1, 1'b1, 16'h0022, 1'b0, 1'b0, 16'h0000, 1'b1, 2'd0);
    vecs[19] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 2'd0);
    // Flush coinciding with a drain, then out_ready on an empty stage.
    vecs[20] = mk(1'b0, 1'b1, 16'h0023, 1'b1, 1'b1, 16'h0023, 1'b1, 2'd1);
    vecs[21] = mk(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 2'd0);
    vecs[22] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 2'd0);

    // Reset held with an entry offered.
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 16'hFFFF;
    in_data   = '1;
    out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_out_valid", DW'(out_valid), DW'(1'b0));
    check("rst_out_ctrl",  DW'(out_ctrl),  DW'(16'h0000));
    check("rst_in_ready",  DW'(in_ready),  DW'(1'b1));
    check("rst_occupancy", DW'(occupancy), DW'(2'd0));
    check("rst_out_data",  out_data,       DW'(0));

    // First accept after reset appears on the next edge.
    reset_n  = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b1;
    in_ctrl  = 16'h00A5;
    in_data  = DW'(1);
    @(posedge clock);
    #1;
    check("first_out_valid", DW'(out_valid), DW'(1'b1));
    check("first_out_ctrl",  DW'(out_ctrl),  DW'(16'h00A5));
    check("first_out_data",  out_data,       DW'(1));
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    check("first_drained", DW'(occupancy), DW'(2'd0));

    // Table-driven vectors.
    for (int i = 0; i < 23; i++) begin
      step(vecs[i].fl, vecs[i].iv, vecs[i].d, vecs[i].ordy);
      check($sformatf("v%0d_out_valid", i), DW'(out_valid), DW'(vecs[i].e_ov));
      check($sformatf("v%0d_out_ctrl", i), DW'(out_ctrl),
            DW'(vecs[i].e_ov ? ctrl_of(vecs[i].e_d) : 16'h0000));
      check($sformatf("v%0d_in_ready", i), DW'(in_ready), DW'(vecs[i].e_ir));
      check($sformatf("v%0d_occupancy", i), DW'(occupancy), DW'(vecs[i].e_occ));
      if (vecs[i].e_ov) begin
        check($sformatf("v%0d_out_data", i), out_data, data_of(vecs[i].e_d));
      end
    end

    // Flush data handling on both data-clear settings.
    step(1'b0, 1'b1, 16'h0030, 1'b0);
    step(1'b0, 1'b1, 16'h0031, 1'b0);
    check("fl_pre_occ", DW'(occupancy), DW'(2'd2));
    check("fl_pre_occ_hold", DW'(h_occupancy), DW'(2'd2));
    step(1'b1, 1'b1, 16'h0032, 1'b0);
    check("fl_clear_data", out_data, DW'(0));
    check("fl_hold_data", h_out_data, data_of(16'h0030));
    check("fl_hold_ctrl", DW'(h_out_ctrl), DW'(16'h0000));
    check("fl_hold_valid", DW'(h_out_valid), DW'(1'b0));
    check("fl_hold_occ", DW'(h_occupancy), DW'(2'd0));
    check("fl_hold_in_ready", DW'(h_in_ready), DW'(1'b1));

    // Asynchronous reset between edges while full.
    step(1'b0, 1'b1, 16'h0040, 1'b0);
    step(1'b0, 1'b1, 16'h0041, 1'b0);
    check("ar_pre_occ", DW'(occupancy), DW'(2'd2));
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_out_valid", DW'(out_valid), DW'(1'b0));
    check("ar_out_ctrl",  DW'(out_ctrl),  DW'(16'h0000));
    check("ar_in_ready",  DW'(in_ready),  DW'(1'b1));
    check("ar_occupancy", DW'(occupancy), DW'(2'd0));
    check("ar_out_data",  out_data,       DW'(0));
    check("ar_hold_data", h_out_data,     DW'(0));
    @(negedge clock);
    reset_n = 1'b1;

`ifdef PIPE_STAGE_PERF_EN
    // 5 stalled cycles, 2 flushes while occupied, 1 flush while empty.
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    step(1'b0, 1'b1, 16'h0050, 1'b0);
    repeat (5) step(1'b0, 1'b0, 16'h0000, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b1);
    step(1'b0, 1'b1, 16'h0051, 1'b1);
    step(1'b1, 1'b0, 16'h0000, 1'b1);
    step(1'b1, 1'b0, 16'h0000, 1'b1);
    check("perf_stall_cnt", DW'(stall_cnt), DW'(32'd5));
    check("perf_flush_cnt", DW'(flush_cnt), DW'(32'd2));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
